u2_batch_accumulator: RTL

U2_BATCH_ACCUMULATOR -- requirements
Module: u2_batch_accumulator

---
 rtl/u2_batch_accumulator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/u2_batch_accumulator.sv
// Batch accumulator: sums 2^n signed m-bit samples exactly into an (m+n)-bit result
// and hands it downstream with a valid/ready handshake.
module u2_batch_accumulator #(
  parameter int m = 4,
  parameter int n = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic signed [m-1:0] i_argA,
  output logic                o_ready,
  output logic [m+n-1:0]      o_result,
  output logic [1:0]          o_status,
  output logic                o_valid,
  input  logic                i_ready
);

  localparam int W = m + n;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_stateNext;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   w_accNext;
  logic [n-1:0]   r_count;
  logic [n-1:0]   w_countNext;
  logic [W-1:0]   r_result;
  logic [W-1:0]   w_resultNext;
  logic [1:0]     r_status;
  logic [1:0]     w_statusNext;
  logic           r_valid;
  logic           w_validNext;
  logic [W-1:0]   w_sampleExt;
  logic [W-1:0]   w_sum;
  logic           w_accept;
  logic           w_lastSample;

  // Ready depends on state only, so there is no combinational path from i_valid/i_ready.
  assign o_ready      = (r_state != DONE);
  assign w_accept     = i_valid & o_ready;
  assign w_sampleExt  = {{n{i_argA[m-1]}}, i_argA};
  assign w_sum        = r_acc + w_sampleExt;
  assign w_lastSample = (r_count == {n{1'b1}});

  assign o_result = r_result;
  assign o_status = r_status;
  assign o_valid  = r_valid;

  always_comb begin
    w_stateNext  = r_state;
    w_accNext    = r_acc;
    w_countNext  = r_count;
    w_resultNext = r_result;
    w_statusNext = r_status;
    w_validNext  = r_valid;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_accNext   = w_sampleExt;
          w_countNext = n'(1);
          w_stateNext = ACC;
        end
      end

      ACC: begin
        if (w_accept) begin
          if (w_lastSample) begin
            w_resultNext = w_sum;
            w_statusNext = {w_sum[W-1], (w_sum == '0)};
            w_validNext  = 1'b1;
            w_accNext    = '0;
            w_countNext  = '0;
            w_stateNext  = DONE;
          end else begin
            w_accNext   = w_sum;
            w_countNext = r_count + n'(1);
          end
        end
      end

      DONE: begin
        // The acknowledge edge only retires the result; a new batch starts on a later edge.
        if (i_ready) begin
          w_validNext  = 1'b0;
          w_statusNext = 2'b00;
          w_accNext    = '0;
          w_countNext  = '0;
          w_stateNext  = IDLE;
        end
      end

      default: begin
        w_validNext  = 1'b0;
        w_statusNext = 2'b00;
        w_accNext    = '0;
        w_countNext  = '0;
        w_stateNext  = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_status <= 2'b00;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_acc    <= w_accNext;
      r_count  <= w_countNext;
      r_result <= w_resultNext;
      r_status <= w_statusNext;
      r_valid  <= w_validNext;
    end
  end

endmodule
